// File: rtl/dsp_mac_pkg.sv
// Shared definitions for the 27x27 multiply-accumulate primitive:
// latency bounds, product width helper and the pipeline control word.
package dsp_mac_pkg;

   localparam int unsigned MIN_LATENCY       = 3;
   localparam int unsigned MAX_LATENCY       = 8;
   localparam int unsigned MIN_OPERAND_WIDTH = 2;
   localparam int unsigned MAX_OPERAND_WIDTH = 27;

   // Control bits that travel alongside each sample
   typedef struct packed {
      logic valid;
      logic acc_en;
      logic acc_load;
   } ctrl_t;

   // Signed product width after one-bit extension of each operand
   function automatic int unsigned prod_width(input int unsigned ax_w, input int unsigned ay_w);
      return ax_w + ay_w + 2;
   endfunction

endpackage

// File: rtl/dsp_mac_27x27_if.sv
// Sample/result bus of the multiply-accumulate primitive.
interface dsp_mac_27x27_if #(
   parameter int unsigned AX_WIDTH  = 27,
   parameter int unsigned AY_WIDTH  = 27,
   parameter int unsigned ACC_WIDTH = 64
);
   logic                 in_valid;
   logic [AX_WIDTH-1:0]  ax;
   logic [AY_WIDTH-1:0]  ay;
   logic                 ax_signed;
   logic                 ay_signed;
   logic                 acc_en;
   logic                 acc_load;
   logic                 out_valid;
   logic [ACC_WIDTH-1:0] result;
   logic                 acc_ovf;

   modport master (
      output in_valid, ax, ay, ax_signed, ay_signed, acc_en, acc_load,
      input  out_valid, result, acc_ovf
   );

   modport slave (
      input  in_valid, ax, ay, ax_signed, ay_signed, acc_en, acc_load,
      output out_valid, result, acc_ovf
   );
endinterface

// File: rtl/dsp_mac_delay.sv
// WIDTH x DEPTH shift register with asynchronous active-low clear;
// DEPTH=0 degenerates to a wire.
module dsp_mac_delay #(
   parameter int unsigned WIDTH = 1,
   parameter int unsigned DEPTH = 1
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic [WIDTH-1:0] i_d,
   output logic [WIDTH-1:0] o_q
);

   if (DEPTH == 0) begin : g_pass
      logic w_unused;
      assign w_unused = clk ^ rst_n;
      assign o_q      = i_d;
   end else begin : g_pipe
      logic [WIDTH-1:0] r_pipe [DEPTH];

      always_ff @(posedge clk or negedge rst_n) begin
         if (!rst_n) begin
            for (int i = 0; i < int'(DEPTH); i++) r_pipe[i] <= '0;
         end else begin
            r_pipe[0] <= i_d;
            for (int i = 1; i < int'(DEPTH); i++) r_pipe[i] <= r_pipe[i-1];
         end
      end

      assign o_q = r_pipe[DEPTH-1];
   end

endmodule

// File: rtl/dsp_mac_27x27.sv
// Multiply-accumulate with per-operand signedness, sticky signed overflow
// and a valid-qualified pipeline of LATENCY stages.
module dsp_mac_27x27
   import dsp_mac_pkg::*;
#(
   parameter              FAMILY    = "Agilex",
   parameter int unsigned LATENCY   = 4,
   parameter int unsigned AX_WIDTH  = 27,
   parameter int unsigned AY_WIDTH  = 27,
   parameter int unsigned ACC_WIDTH = 64
) (
   input  logic            clk,
   input  logic            rst_n,
   dsp_mac_27x27_if.slave  bus
);

   localparam int unsigned PW      = prod_width(AX_WIDTH, AY_WIDTH);
   localparam int unsigned DEPTH   = LATENCY - MIN_LATENCY;
   localparam int unsigned OUT_W   = ACC_WIDTH + 2;

   if (LATENCY < MIN_LATENCY || LATENCY > MAX_LATENCY) begin : g_bad_latency
      $error("dsp_mac_27x27: LATENCY %0d outside %0d..%0d", LATENCY, MIN_LATENCY, MAX_LATENCY);
   end
   if (AX_WIDTH < MIN_OPERAND_WIDTH || AX_WIDTH > MAX_OPERAND_WIDTH ||
       AY_WIDTH < MIN_OPERAND_WIDTH || AY_WIDTH > MAX_OPERAND_WIDTH) begin : g_bad_operand
      $error("dsp_mac_27x27: operand widths %0d/%0d outside 2..27", AX_WIDTH, AY_WIDTH);
   end
   if (ACC_WIDTH < AX_WIDTH + AY_WIDTH + 1) begin : g_bad_acc
      $error("dsp_mac_27x27: ACC_WIDTH %0d too narrow", ACC_WIDTH);
   end
   if ($bits(FAMILY) < 8) begin : g_bad_family
      $error("dsp_mac_27x27: FAMILY must be a non-empty string");
   end

   // Stage 1: operand and control capture
   ctrl_t               r_s1_ctrl;
   logic [AX_WIDTH-1:0] r_s1_ax;
   logic [AY_WIDTH-1:0] r_s1_ay;
   logic                r_s1_ax_sgn;
   logic                r_s1_ay_sgn;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_s1_ctrl   <= '0;
         r_s1_ax     <= '0;
         r_s1_ay     <= '0;
         r_s1_ax_sgn <= 1'b0;
         r_s1_ay_sgn <= 1'b0;
      end else begin
         r_s1_ctrl.valid <= bus.in_valid;
         if (bus.in_valid) begin
            r_s1_ctrl.acc_en   <= bus.acc_en;
            r_s1_ctrl.acc_load <= bus.acc_load;
            r_s1_ax            <= bus.ax;
            r_s1_ay            <= bus.ay;
            r_s1_ax_sgn        <= bus.ax_signed;
            r_s1_ay_sgn        <= bus.ay_signed;
         end
      end
   end

   // Stage 2: one-bit extension makes every operand mode a signed multiply
   logic signed [AX_WIDTH:0] w_ax_ext;
   logic signed [AY_WIDTH:0] w_ay_ext;
   logic signed [PW-1:0]     w_prod;

   assign w_ax_ext = {r_s1_ax_sgn & r_s1_ax[AX_WIDTH-1], r_s1_ax};
   assign w_ay_ext = {r_s1_ay_sgn & r_s1_ay[AY_WIDTH-1], r_s1_ay};
   assign w_prod   = PW'(w_ax_ext) * PW'(w_ay_ext);

   ctrl_t                       r_s2_ctrl;
   logic signed [ACC_WIDTH-1:0] r_s2_prod;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_s2_ctrl <= '0;
         r_s2_prod <= '0;
      end else begin
         r_s2_ctrl <= r_s1_ctrl;
         r_s2_prod <= ACC_WIDTH'(w_prod);
      end
   end

   // Stage 3: accumulator; bubbles leave sum and flag untouched
   logic [ACC_WIDTH-1:0] r_acc;
   logic                 r_ovf;
   logic                 r_s3_valid;
   logic [ACC_WIDTH-1:0] w_sum;
   logic                 w_add_ovf;

   assign w_sum     = r_acc + r_s2_prod;
   assign w_add_ovf = (r_acc[ACC_WIDTH-1] == r_s2_prod[ACC_WIDTH-1]) &&
                      (w_sum[ACC_WIDTH-1] != r_acc[ACC_WIDTH-1]);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_acc      <= '0;
         r_ovf      <= 1'b0;
         r_s3_valid <= 1'b0;
      end else begin
         r_s3_valid <= r_s2_ctrl.valid;
         if (r_s2_ctrl.valid) begin
            if (!r_s2_ctrl.acc_en) begin
               r_acc <= r_s2_prod;
            end else if (r_s2_ctrl.acc_load) begin
               r_acc <= r_s2_prod;
               r_ovf <= 1'b0;
            end else begin
               r_acc <= w_sum;
               if (w_add_ovf) r_ovf <= 1'b1;
            end
         end
      end
   end

   // Stages 4..LATENCY: pure delay of valid, flag and sum
   logic [OUT_W-1:0] w_out;

   dsp_mac_delay #(
      .WIDTH (OUT_W),
      .DEPTH (DEPTH)
   ) u_delay (
      .clk   (clk),
      .rst_n (rst_n),
      .i_d   ({r_s3_valid, r_ovf, r_acc}),
      .o_q   (w_out)
   );

   assign {bus.out_valid, bus.acc_ovf, bus.result} = w_out;

endmodule

// File: tb/tb_dsp_mac_27x27.sv
// Bench for dsp_mac_27x27: three configurations driven in lock-step and
// scored every cycle against an arithmetic model of multiply-accumulate.
module tb_dsp_mac_27x27;

   logic clk;
   logic rst_n;

   logic        d_iv, d_sa, d_sb, d_en, d_ld;
   logic [26:0] d_ax, d_ay;

   dsp_mac_27x27_if #(.AX_WIDTH(27), .AY_WIDTH(27), .ACC_WIDTH(64)) bus0 ();
   dsp_mac_27x27_if #(.AX_WIDTH(27), .AY_WIDTH(27), .ACC_WIDTH(55)) bus1 ();
   dsp_mac_27x27_if #(.AX_WIDTH(27), .AY_WIDTH(27), .ACC_WIDTH(64)) bus2 ();

   assign bus0.in_valid = d_iv;  assign bus1.in_valid = d_iv;  assign bus2.in_valid = d_iv;
   assign bus0.ax = d_ax;        assign bus1.ax = d_ax;        assign bus2.ax = d_ax;
   assign bus0.ay = d_ay;        assign bus1.ay = d_ay;        assign bus2.ay = d_ay;
   assign bus0.ax_signed = d_sa; assign bus1.ax_signed = d_sa; assign bus2.ax_signed = d_sa;
   assign bus0.ay_signed = d_sb; assign bus1.ay_signed = d_sb; assign bus2.ay_signed = d_sb;
   assign bus0.acc_en = d_en;    assign bus1.acc_en = d_en;    assign bus2.acc_en = d_en;
   assign bus0.acc_load = d_ld;  assign bus1.acc_load = d_ld;  assign bus2.acc_load = d_ld;

   dsp_mac_27x27 #(.LATENCY(4), .ACC_WIDTH(64)) u_l4 (.clk(clk), .rst_n(rst_n), .bus(bus0));
   dsp_mac_27x27 #(.LATENCY(3), .ACC_WIDTH(55)) u_l3 (.clk(clk), .rst_n(rst_n), .bus(bus1));
   dsp_mac_27x27 #(.LATENCY(8), .ACC_WIDTH(64)) u_l8 (.clk(clk), .rst_n(rst_n), .bus(bus2));

   initial clk = 1'b0;
   always #5 clk = ~clk;

   localparam int NCYC = 4096;
   int unsigned lat [3] = '{4, 3, 8};
   int unsigned wid [3] = '{64, 55, 64};

   int n_chk  = 0;
   int n_pass = 0;
   int cyc    = 0;

   bit        exp_v [3][NCYC];
   bit [63:0] exp_r [3][NCYC];
   bit        exp_o [3][NCYC];
   bit [63:0] last_r [3];
   bit        last_o [3];
   logic signed [127:0] acc_m [3];
   bit        ovf_m [3];

   bit        cap0, cap1;
   logic [63:0] q_res0 [$];
   logic [63:0] q_res1 [$];
   bit          q_ovf1 [$];

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
      n_chk++;
      assert (obs === expv) n_pass++;
      else $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
   endtask

   function automatic logic signed [127:0] opval(input logic [26:0] v, input bit s);
      logic signed [127:0] r;
      r = {101'd0, v};
      if (s && v[26]) r = r - (128'sd1 <<< 27);
      return r;
   endfunction

   function automatic logic signed [127:0] wrap(input logic signed [127:0] x, input int unsigned w);
      logic signed [127:0] m, r;
      m = 128'sd1 <<< w;
      r = x & (m - 128'sd1);
      if (r >= (m >>> 1)) r = r - m;
      return r;
   endfunction

   function automatic logic [63:0] mask(input int unsigned w);
      return (w >= 64) ? 64'hFFFF_FFFF_FFFF_FFFF : ((64'd1 << w) - 64'd1);
   endfunction

   // Reference: exact integer product, sum checked against the signed range
   task automatic model_step(input int d);
      logic signed [127:0] p, ex, lim;
      int idx;
      p   = opval(d_ax, d_sa) * opval(d_ay, d_sb);
      lim = 128'sd1 <<< (wid[d] - 1);
      if (!d_en) begin
         acc_m[d] = wrap(p, wid[d]);
      end else if (d_ld) begin
         acc_m[d] = wrap(p, wid[d]);
         ovf_m[d] = 1'b0;
      end else begin
         ex = acc_m[d] + p;
         if (ex >= lim || ex < -lim) ovf_m[d] = 1'b1;
         acc_m[d] = wrap(ex, wid[d]);
      end
      idx = cyc + int'(lat[d]) - 1;
      if (idx < NCYC) begin
         exp_v[d][idx] = 1'b1;
         exp_r[d][idx] = 64'(acc_m[d]) & mask(wid[d]);
         exp_o[d][idx] = ovf_m[d];
      end
   endtask

   task automatic model_reset();
      for (int d = 0; d < 3; d++) begin
         for (int k = cyc + 1; k < NCYC; k++) exp_v[d][k] = 1'b0;
         acc_m[d]  = '0;
         ovf_m[d]  = 1'b0;
         last_r[d] = '0;
         last_o[d] = 1'b0;
      end
   endtask

   task automatic score();
      logic [63:0] r_obs;
      bit v_obs, o_obs, ev;
      for (int d = 0; d < 3; d++) begin
         ev = (cyc < NCYC) ? exp_v[d][cyc] : 1'b0;
         if (ev) begin
            last_r[d] = exp_r[d][cyc];
            last_o[d] = exp_o[d][cyc];
         end
         case (d)
            0:       begin v_obs = bus0.out_valid; r_obs = bus0.result;      o_obs = bus0.acc_ovf; end
            1:       begin v_obs = bus1.out_valid; r_obs = 64'(bus1.result); o_obs = bus1.acc_ovf; end
            default: begin v_obs = bus2.out_valid; r_obs = bus2.result;      o_obs = bus2.acc_ovf; end
         endcase
         chk($sformatf("out_valid[L%0d]@%0d", lat[d], cyc), 64'(v_obs), 64'(ev));
         chk($sformatf("result[L%0d]@%0d", lat[d], cyc), r_obs, last_r[d]);
         chk($sformatf("acc_ovf[L%0d]@%0d", lat[d], cyc), 64'(o_obs), 64'(last_o[d]));
      end
   endtask

   // One clock: inputs sampled at the edge, outputs checked 1 time unit later
   task automatic tick();
      @(posedge clk);
      #1;
      cyc++;
      if (rst_n && d_iv) for (int d = 0; d < 3; d++) model_step(d);
      score();
      if (cap0 && bus0.out_valid) q_res0.push_back(bus0.result);
      if (cap1 && bus1.out_valid) begin
         q_res1.push_back(64'(bus1.result));
         q_ovf1.push_back(bus1.acc_ovf);
      end
   endtask

   task automatic send(input logic [26:0] a, input logic [26:0] b, input bit sa, input bit sb,
                       input bit en, input bit ld);
      d_iv = 1'b1; d_ax = a; d_ay = b; d_sa = sa; d_sb = sb; d_en = en; d_ld = ld;
      tick();
   endtask

   task automatic idle(input int n);
      d_iv = 1'b0;
      repeat (n) tick();
   endtask

   function automatic logic [26:0] rand_op();
      case ($urandom_range(0, 7))
         0:       return 27'h4000000;
         1:       return 27'h7FFFFFF;
         default: return 27'($urandom());
      endcase
   endfunction

   task automatic send_rand(input bit force_valid);
      d_iv = force_valid ? 1'b1 : ($urandom_range(0, 3) != 0);
      d_ax = rand_op();
      d_ay = rand_op();
      d_sa = 1'($urandom_range(0, 1));
      d_sb = 1'($urandom_range(0, 1));
      d_en = ($urandom_range(0, 9) < 7);
      d_ld = ($urandom_range(0, 4) == 0);
      tick();
   endtask

   function automatic logic [63:0] q_at(input logic [63:0] q [$], input int k);
      return (q.size() > k) ? q[k] : 64'hDEAD_DEAD_DEAD_DEAD;
   endfunction

   initial begin
      logic [63:0] p26;
      rst_n = 1'b0;
      d_iv = 1'b0; d_ax = '0; d_ay = '0; d_sa = 1'b0; d_sb = 1'b0; d_en = 1'b0; d_ld = 1'b0;
      cap0 = 1'b0; cap1 = 1'b0;
      for (int d = 0; d < 3; d++) begin acc_m[d] = '0; ovf_m[d] = 1'b0; end

      // Reset state
      repeat (2) @(posedge clk);
      #1;
      chk("reset_out_valid_l4", 64'(bus0.out_valid), 64'd0);
      chk("reset_result_l4",    bus0.result,         64'd0);
      chk("reset_acc_ovf_l4",   64'(bus0.acc_ovf),   64'd0);
      chk("reset_out_valid_l3", 64'(bus1.out_valid), 64'd0);
      chk("reset_result_l3",    64'(bus1.result),    64'd0);
      chk("reset_out_valid_l8", 64'(bus2.out_valid), 64'd0);
      chk("reset_result_l8",    bus2.result,         64'd0);
      rst_n = 1'b1;
      idle(2);

      // Unsigned full-scale pass-through
      send(27'h7FFFFFF, 27'h7FFFFFF, 1'b0, 1'b0, 1'b0, 1'b0);
      idle(3);
      chk("unsigned_max_valid",  64'(bus0.out_valid), 64'd1);
      chk("unsigned_max_result", bus0.result, 64'd18014398241046529);

      // Mixed signedness, then the same bits unsigned
      send(27'h4000000, 27'd3, 1'b1, 1'b0, 1'b0, 1'b0);
      send(27'h4000000, 27'd3, 1'b0, 1'b0, 1'b0, 1'b0);
      idle(2);
      chk("mixed_signed_result", bus0.result, -64'sd201326592);
      idle(1);
      chk("mixed_unsigned_result", bus0.result, 64'd201326592);

      // Accumulate across a two-cycle bubble
      idle(4);
      q_res0.delete();
      cap0 = 1'b1;
      send(27'd5, 27'd7, 1'b0, 1'b0, 1'b1, 1'b1);
      idle(2);
      send(27'h7FFFFFD, 27'd4, 1'b1, 1'b1, 1'b1, 1'b0);
      send(27'd10, 27'd10, 1'b0, 1'b0, 1'b1, 1'b0);
      idle(4);
      cap0 = 1'b0;
      chk("bubble_out_count", 64'(q_res0.size()), 64'd3);
      chk("bubble_sum0", q_at(q_res0, 0), 64'd35);
      chk("bubble_sum1", q_at(q_res0, 1), 64'd23);
      chk("bubble_sum2", q_at(q_res0, 2), 64'd123);

      // Overflow on the 55-bit accumulator, then cleared by a load
      q_res1.delete();
      q_ovf1.delete();
      cap1 = 1'b1;
      send(27'h3FFFFFF, 27'h3FFFFFF, 1'b0, 1'b0, 1'b1, 1'b1);
      repeat (5) send(27'h3FFFFFF, 27'h3FFFFFF, 1'b0, 1'b0, 1'b1, 1'b0);
      send(27'h3FFFFFF, 27'h3FFFFFF, 1'b0, 1'b0, 1'b1, 1'b1);
      idle(3);
      cap1 = 1'b0;
      p26 = 64'h3FFFFFF * 64'h3FFFFFF;
      chk("ovf_out_count", 64'(q_ovf1.size()), 64'd7);
      for (int k = 0; k < 7; k++)
         chk($sformatf("ovf_flag_%0d", k), 64'((q_ovf1.size() > k) ? q_ovf1[k] : 1'b0),
             64'(k == 4 || k == 5));
      chk("ovf_wrap_negative", 64'(q_at(q_res1, 4) >> 54), 64'd1);
      chk("ovf_load_result", q_at(q_res1, 6), p26 & mask(55));

      // Reset in the middle of a continuous stream
      idle(10);
      repeat (6) send_rand(1'b1);
      rst_n = 1'b0;
      d_iv  = 1'b0;
      #1;
      chk("midrst_out_valid_l4", 64'(bus0.out_valid), 64'd0);
      chk("midrst_result_l4",    bus0.result,         64'd0);
      chk("midrst_acc_ovf_l4",   64'(bus0.acc_ovf),   64'd0);
      chk("midrst_out_valid_l3", 64'(bus1.out_valid), 64'd0);
      chk("midrst_result_l3",    64'(bus1.result),    64'd0);
      chk("midrst_acc_ovf_l3",   64'(bus1.acc_ovf),   64'd0);
      chk("midrst_out_valid_l8", 64'(bus2.out_valid), 64'd0);
      chk("midrst_result_l8",    bus2.result,         64'd0);
      model_reset();
      tick();
      rst_n = 1'b1;
      idle(2);
      for (int i = 0; i < 4; i++) begin
         send_rand(1'b1);
         chk($sformatf("postrst_first_valid_%0d", i), 64'(bus0.out_valid), 64'(i == 3));
      end

      // Random regression
      repeat (1000) send_rand(1'b0);
      idle(10);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule

// File: doc/dsp_mac_27x27.md
Name: dsp_mac_27x27

Overview:
Parametrised successor to the fixed 27x27 unsigned multiplier. Computes ax*ay with per-sample signedness selection for each operand and an optional running accumulator, behind a valid-qualified pipeline of configurable depth. It sits in the DSP cookbook as the reference multiply-accumulate primitive for filters and dot products. It maps to one hard DSP block in 27x27 mode, with the accumulator in the DSP chainout/accumulate path.

Parameters:
FAMILY, "Agilex", target device family string; passed through only, no functional effect.
LATENCY, 4, input-sample-to-output cycles; legal range 3..8; elaboration error outside the range.
AX_WIDTH, 27, ax operand width; legal range 2..27.
AY_WIDTH, 27, ay operand width; legal range 2..27.
ACC_WIDTH, 64, accumulator/result width; must be >= AX_WIDTH+AY_WIDTH+1; elaboration error otherwise.

Ports:
clk  in  1  clock; all state on the rising edge.
rst_n  in  1  asynchronous, active-low reset.
in_valid  in  1  qualifies ax, ay, ax_signed, ay_signed, acc_load and acc_en this cycle.
ax  in  AX_WIDTH  operand X.
ay  in  AY_WIDTH  operand Y.
ax_signed  in  1  1 = ax is two's complement; 0 = ax is unsigned.
ay_signed  in  1  1 = ay is two's complement; 0 = ay is unsigned.
acc_en  in  1  1 = add the product to the accumulator; 0 = pass the product through.
acc_load  in  1  1 = restart the sum at this product; clears the overflow flag.
out_valid  out  1  result is valid this cycle.
result  out  ACC_WIDTH  signed product or accumulated sum.
acc_ovf  out  1  sticky signed-overflow flag of the accumulator.

Behaviour:
- Reset (rst_n low, asynchronous): every pipeline register, the accumulator, out_valid, result and acc_ovf go to 0. Release takes effect at the next clk edge.
- Reset mid-operation: all in-flight samples are discarded. Nothing emerges after release until new in_valid samples arrive.
- Stage 1 registers the inputs and control bits, gated by in_valid; the valid bit always propagates.
- Stage 2 extends each operand by one bit: sign-extension if its signed flag is 1, zero-extension otherwise. It multiplies to a signed AX_WIDTH+AY_WIDTH+2-bit product, then sign-extends the product to ACC_WIDTH.
- Stage 3 is the accumulate stage, and it updates only when its valid bit is 1:
  - acc_en=0: acc <= product; acc_ovf unchanged.
  - acc_en=1, acc_load=1: acc <= product; acc_ovf <= 0.
  - acc_en=1, acc_load=0: acc <= acc + product, wrapping modulo 2^ACC_WIDTH. acc_ovf is set if the signed add overflows (operands of equal sign, result of different sign).
  - acc_load with acc_en=0 behaves as plain pass-through and does not clear acc_ovf.
- Bubbles (valid=0 at stage 3) leave acc and acc_ovf untouched. An accumulation sequence may therefore contain gaps of any length.
- Stages 4..LATENCY are pure delay registers for result, out_valid and acc_ovf. Each sample with in_valid=1 at edge N produces out_valid=1 with its result at edge N+LATENCY.
- result and acc_ovf hold their last values while out_valid=0; they are not cleared.
- Throughput: one sample per cycle, with no back-pressure.
- Back-to-back load samples each restart the sum independently.

Decomposition:
- Package dsp_mac_pkg holds:
  - localparams MIN_LATENCY=3 and MAX_LATENCY=8;
  - function prod_width(ax_w, ay_w) returning ax_w+ay_w+2;
  - typedef ctrl_t, a packed struct {valid, acc_en, acc_load} carried down the pipeline.
- One sub-module, dsp_mac_delay: a parametrised WIDTH x DEPTH shift register with asynchronous active-low reset to 0. It is used for the post-accumulate stages; DEPTH=0 is a passthrough.

Test Plan:
- Unsigned pass-through: ax=2^27-1, ay=2^27-1, both signed flags 0, acc_en=0 -> 4 cycles later out_valid=1, result=18014398241046529.
- Mixed signedness: ax=0x4000000 with ax_signed=1 (value -67108864), ay=3 unsigned -> result=-201326592. The same operands with both flags 0 -> result=201326592.
- Accumulate with a bubble: load with 5*7, then in_valid=0 for 2 cycles, then accumulate -3*4 (signed), then accumulate 10*10 -> the three outputs are 35, 23, 123, with out_valid high exactly 3 times.
- Overflow: ACC_WIDTH=55, accumulate (2^26-1)^2 unsigned repeatedly -> acc_ovf rises on the sample that wraps the sum negative and stays high. The next load sample clears it, with result equal to that product.
- Reset mid-stream: drive continuous valid samples and assert rst_n low for 1 cycle mid-stream -> out_valid, result and acc_ovf are 0 immediately. No out_valid appears until LATENCY cycles after the first post-reset sample.
- Random regression at LATENCY 3 and 8: 1000 random samples with random signed flags, acc_en, acc_load and in_valid -> compare against a golden model.
